// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the hh:mm:ss countdown timer.
//   state_e          - controller states (IDLE, RUN, PAUSED, EXPIRED)
//   HRS_W/MIN_W/SEC_W - field widths of the hours/minutes/seconds registers
//   *_MAX_DEF        - default largest value of each field
package countdown_pkg;

  localparam int HRS_W = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam logic [HRS_W-1:0] HRS_MAX_DEF = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX_DEF = 6'd59;
  localparam logic [SEC_W-1:0] SEC_MAX_DEF = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control and status bundle of the countdown timer.
//   tick, load, load_hrs/min/sec, start, pause : controls into the timer
//   hrs, min, sec, running, expired, done      : registered status out of it
//   modport master - the controlling side; modport slave - the timer.
interface countdown_timer_if;
  import countdown_pkg::*;

  logic             tick;
  logic             load;
  logic [HRS_W-1:0] load_hrs;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic             start;
  logic             pause;
  logic [HRS_W-1:0] hrs;
  logic [MIN_W-1:0] min;
  logic [SEC_W-1:0] sec;
  logic             running;
  logic             expired;
  logic             done;

  modport master (
    output tick, load, load_hrs, load_min, load_sec, start, pause,
    input  hrs, min, sec, running, expired, done
  );

  modport slave (
    input  tick, load, load_hrs, load_min, load_sec, start, pause,
    output hrs, min, sec, running, expired, done
  );

endinterface

// File: rtl/countdown_timer_hms_dec.sv
// hms_dec: combinational one-second decrement of an hh:mm:ss value.
//   hrs/min/sec          in  - current value
//   hrs_dec/min_dec/sec_dec out - value one second earlier (borrowing upward)
//   zero_next            out - decremented value is 00:00:00
// A 00:00:00 input passes through unchanged; the caller never decrements it.
module hms_dec
  import countdown_pkg::*;
#(
  parameter logic [MIN_W-1:0] MIN_MAX = MIN_MAX_DEF,
  parameter logic [SEC_W-1:0] SEC_MAX = SEC_MAX_DEF
) (
  input  logic [HRS_W-1:0] hrs,
  input  logic [MIN_W-1:0] min,
  input  logic [SEC_W-1:0] sec,
  output logic [HRS_W-1:0] hrs_dec,
  output logic [MIN_W-1:0] min_dec,
  output logic [SEC_W-1:0] sec_dec,
  output logic             zero_next
);

  // Borrow chain: seconds first, then minutes, then hours.
  always_comb begin
    hrs_dec = hrs;
    min_dec = min;
    sec_dec = sec;
    if (sec != {SEC_W{1'b0}}) begin
      sec_dec = sec - 6'd1;
    end else if (min != {MIN_W{1'b0}}) begin
      sec_dec = SEC_MAX;
      min_dec = min - 6'd1;
    end else if (hrs != {HRS_W{1'b0}}) begin
      sec_dec = SEC_MAX;
      min_dec = MIN_MAX;
      hrs_dec = hrs - 5'd1;
    end else begin
      sec_dec = sec;
    end
  end

  // Flag the decrement that lands on zero so the controller can expire.
  always_comb begin
    zero_next = (hrs_dec == {HRS_W{1'b0}}) && (min_dec == {MIN_W{1'b0}}) &&
                (sec_dec == {SEC_W{1'b0}});
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: hh:mm:ss countdown driven by an external one-second tick.
//   clk  - system clock, all updates on its rising edge
//   rst  - synchronous active-high reset
//   bus  - countdown_timer_if.slave: load/start/pause/tick controls in,
//          registered hrs/min/sec/running/expired/done out
// Per-cycle priority: rst, load, pause, start, tick.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter logic [HRS_W-1:0] HRS_MAX = HRS_MAX_DEF,
  parameter logic [MIN_W-1:0] MIN_MAX = MIN_MAX_DEF,
  parameter logic [SEC_W-1:0] SEC_MAX = SEC_MAX_DEF
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave bus
);

  state_e           state_r, state_nxt_s;
  logic [HRS_W-1:0] hrs_r, hrs_nxt_s, hrs_dec_s;
  logic [MIN_W-1:0] min_r, min_nxt_s, min_dec_s;
  logic [SEC_W-1:0] sec_r, sec_nxt_s, sec_dec_s;
  logic             zero_next_s;
  logic             cur_zero_s;
  logic             dec_en_s;
  logic             done_r, done_nxt_s;
  logic             running_r, expired_r;

  hms_dec #(
    .MIN_MAX (MIN_MAX),
    .SEC_MAX (SEC_MAX)
  ) u_dec (
    .hrs       (hrs_r),
    .min       (min_r),
    .sec       (sec_r),
    .hrs_dec   (hrs_dec_s),
    .min_dec   (min_dec_s),
    .sec_dec   (sec_dec_s),
    .zero_next (zero_next_s)
  );

  // Qualifiers: a tick only counts in RUN when nothing of higher priority is active.
  always_comb begin
    cur_zero_s = (hrs_r == {HRS_W{1'b0}}) && (min_r == {MIN_W{1'b0}}) &&
                 (sec_r == {SEC_W{1'b0}});
    dec_en_s   = (state_r == RUN) && bus.tick && !bus.pause && !bus.load;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.load) begin
      state_nxt_s = IDLE;
    end else if (bus.pause) begin
      // Pause only matters in RUN; it also masks start in every state.
      if (state_r == RUN) begin
        state_nxt_s = PAUSED;
      end else begin
        state_nxt_s = state_r;
      end
    end else if (dec_en_s && zero_next_s) begin
      state_nxt_s = EXPIRED;
    end else if (bus.start) begin
      case (state_r)
        IDLE:    state_nxt_s = cur_zero_s ? EXPIRED : RUN;
        PAUSED:  state_nxt_s = RUN;
        RUN:     state_nxt_s = RUN;
        EXPIRED: state_nxt_s = EXPIRED;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output/datapath next values: clamped load, decrement, or hold.
  always_comb begin
    hrs_nxt_s = hrs_r;
    min_nxt_s = min_r;
    sec_nxt_s = sec_r;
    if (bus.load) begin
      hrs_nxt_s = (bus.load_hrs > HRS_MAX) ? HRS_MAX : bus.load_hrs;
      min_nxt_s = (bus.load_min > MIN_MAX) ? MIN_MAX : bus.load_min;
      sec_nxt_s = (bus.load_sec > SEC_MAX) ? SEC_MAX : bus.load_sec;
    end else if (dec_en_s) begin
      hrs_nxt_s = hrs_dec_s;
      min_nxt_s = min_dec_s;
      sec_nxt_s = sec_dec_s;
    end else begin
      hrs_nxt_s = hrs_r;
    end
    // EXPIRED can only be entered from another state, so entry marks the pulse.
    done_nxt_s = (state_nxt_s == EXPIRED) && (state_r != EXPIRED);
  end

  // Registered time value and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hrs_r     <= {HRS_W{1'b0}};
      min_r     <= {MIN_W{1'b0}};
      sec_r     <= {SEC_W{1'b0}};
      done_r    <= 1'b0;
      running_r <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      hrs_r     <= hrs_nxt_s;
      min_r     <= min_nxt_s;
      sec_r     <= sec_nxt_s;
      done_r    <= done_nxt_s;
      running_r <= (state_nxt_s == RUN);
      expired_r <= (state_nxt_s == EXPIRED);
    end
  end

  assign bus.hrs     = hrs_r;
  assign bus.min     = min_r;
  assign bus.sec     = sec_r;
  assign bus.running = running_r;
  assign bus.expired = expired_r;
  assign bus.done    = done_r;

endmodule
